dma_addr_latch_ext: RTL
=======================

# dma_addr_latch_ext

Parametrised, clocked address latch for the DMA controller. It generates the system address in both bus modes. In CPU mode (AEN=0) it captures the multiplexed CPU address on ALE. In DMA mode (AEN=1) it captures the middle address byte from the data bus on ADSTB, takes the low byte directly from the controller, and supplies the upper bits from a per-channel page register bank, which can optionally auto-increment on a middle-byte wrap.

## Interface
- ADDR_W, 24: total address width; multiple of 8, at least 16; page width PG_W = ADDR_W-16.
- NCH, 4: number of DMA channels / page registers; CH_W = $clog2(NCH), minimum 1.
- PAGE_INC, 1: 1 = page auto-increments on a middle-byte wrap in DMA mode; 0 = page is fixed.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- AEN  in  1  address enable; 1 = DMA owns the bus.
- ALE  in  1  CPU address latch enable, active high, level.
- ADSTB  in  1  DMA upper-address strobe, active high, level.
- AD15_AD0  in  16  multiplexed CPU address/data bus; also carries the DMA middle byte on bits [15:8].
- A_HI  in  PG_W  CPU upper address bits, captured together with ALE.
- DMA_A_LO  in  8  DMA low address byte (A7-A0) driven by the controller.
- DACK_CH  in  CH_W  encoded number of the active DMA channel.
- PAGE_WE  in  1  CPU page register write strobe.
- PAGE_SEL  in  CH_W  page register index for write and readback.
- PAGE_WDATA  in  PG_W  page write data.
- Address  out  ADDR_W  composed system address.
- ADDR_OE_LO  out  1  drive enable for Address[7:0]; equals ~AEN, combinational.
- PAGE_RDATA  out  PG_W  page[PAGE_SEL], combinational readback.
- WRAP_PULSE  out  1  one-cycle pulse when a middle-byte wrap is detected.

## Operation
- Latch emulation. Registers track their inputs on every clock while the strobe is high and hold while it is low.
  - ALE high: cpu_lo_q <= AD15_AD0 and cpu_hi_q <= A_HI.
  - Middle byte: mid_q <= AD15_AD0[15:8] when the middle strobe is high. The middle strobe is ADSTB when AEN=1, else ALE.
- Address composition:
  - AEN=0: Address = {cpu_hi_q, cpu_lo_q}.
  - AEN=1: Address = {page[DACK_CH], mid_q, DMA_A_LO}. DMA_A_LO passes through combinationally; mid_q is the registered value.
- Page registers: NCH x PG_W. A write to page[PAGE_SEL] occurs only when PAGE_WE=1 and AEN=0; PAGE_WE with AEN=1 is ignored.
- Wrap detection, DMA mode only:
  - On each ADSTB falling edge (adstb_q=1, ADSTB=0) with AEN=1, compare mid_q with mid_prev_q, then update mid_prev_q <= mid_q.
  - mid_prev_q=8'hFF and mid_q=8'h00: WRAP_PULSE=1 for the next cycle. If PAGE_INC=1, page[DACK_CH] increments modulo 2^PG_W in the same edge.
- DACK_CH >= NCH: reads return 0, increments are suppressed, and WRAP_PULSE still asserts.
- AEN falling to 0 mid-transfer: mid_prev_q holds its value; a pending wrap comparison is discarded.

## Timing
- Reset (RESET_N=0, asynchronous): all registers, pages, mid_prev_q and adstb_q clear to 0. Address=0 and WRAP_PULSE=0. ADDR_OE_LO follows ~AEN.
- Capture latency: 1 clock. A value present while the strobe is high appears on Address one cycle after the rising edge that samples it.
- Page write is visible on PAGE_RDATA and Address one cycle after the write edge.
- Wrap: WRAP_PULSE is high for exactly the cycle after the ADSTB falling-edge sample; the incremented page is visible in that same cycle.
- Strobe held high over several cycles: the last sampled value wins.
- ALE and ADSTB both high with AEN=1: only the ADSTB path updates mid_q. cpu_lo_q still updates from ALE.
- RESET_N asserted mid-transfer: immediate clear; no WRAP_PULSE on release.

## Test plan
- Reset: with RESET_N=0 and random inputs, Address=0, WRAP_PULSE=0 and all PAGE_RDATA=0. After release with AEN=0, ADDR_OE_LO=1.
- CPU capture:
  - AEN=0, A_HI=8'h12, AD15_AD0=16'h3456, ALE pulsed one cycle -> Address=24'h123456 on the next cycle.
  - AD15_AD0 changed after ALE falls -> Address unchanged.
- Page write and DMA compose:
  - PAGE_WE, PAGE_SEL=2, PAGE_WDATA=8'hA5 with AEN=0 -> PAGE_RDATA=8'hA5.
  - Then AEN=1, DACK_CH=2, ADSTB pulse with AD15_AD0[15:8]=8'h7C, DMA_A_LO=8'h31 -> Address=24'hA57C31 and ADDR_OE_LO=0.
- Wrap with PAGE_INC=1: page[1]=8'h0F, ADSTB strobes of 8'hFF then 8'h00 -> WRAP_PULSE for one cycle and page[1]=8'h10. A second 8'hFF to 8'h00 sequence with page[1]=8'hFF -> page[1] wraps to 8'h00.
- Ignored write and PAGE_INC=0 build:
  - PAGE_WE with AEN=1 -> page unchanged.
  - With PAGE_INC=0, the same FF to 00 sequence -> WRAP_PULSE=1 and page unchanged.
- Asynchronous reset during a DMA burst, mid ADSTB high -> outputs clear within the same cycle; no pulse after release.

Source files
------------

// File: rtl/dma_addr_latch_ext.sv
// dma_addr_latch_ext: system address generator for the DMA controller.
// CPU mode (AEN=0) latches the multiplexed CPU address on ALE.
// DMA mode (AEN=1) composes {page[DACK_CH], mid byte latched on ADSTB, DMA_A_LO}.
// The per-channel page registers can step up when the middle byte wraps FF->00.
module dma_addr_latch_ext #(
  parameter  int ADDR_W   = 24,
  parameter  int NCH      = 4,
  parameter  int PAGE_INC = 1,
  localparam int PG_W     = ADDR_W - 16,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              AEN,
  input  logic              ALE,
  input  logic              ADSTB,
  input  logic [15:0]       AD15_AD0,
  input  logic [PG_W-1:0]   A_HI,
  input  logic [7:0]        DMA_A_LO,
  input  logic [CH_W-1:0]   DACK_CH,
  input  logic              PAGE_WE,
  input  logic [CH_W-1:0]   PAGE_SEL,
  input  logic [PG_W-1:0]   PAGE_WDATA,
  output logic [ADDR_W-1:0] Address,
  output logic              ADDR_OE_LO,
  output logic [PG_W-1:0]   PAGE_RDATA,
  output logic              WRAP_PULSE
);

  logic [15:0]            cpu_lo_q;
  logic [PG_W-1:0]        cpu_hi_q;
  logic [7:0]             mid_q;
  logic [7:0]             mid_prev_q;
  logic                   adstb_q;
  logic                   wrap_q;
  logic [NCH-1:0][PG_W-1:0] page;

  logic                   mid_stb;
  logic                   adstb_fall;
  logic                   wrap_det;
  logic                   page_we_ok;
  logic                   inc_ok;
  logic [PG_W-1:0]        pg_dma;
  logic [PG_W-1:0]        pg_rd;

  // The middle byte follows whichever strobe owns the bus.
  assign mid_stb    = AEN ? ADSTB : ALE;
  // Falling ADSTB only counts while DMA still owns the bus; otherwise the
  // pending comparison is simply dropped.
  assign adstb_fall = AEN & adstb_q & ~ADSTB;
  assign wrap_det   = adstb_fall & (mid_prev_q == 8'hFF) & (mid_q == 8'h00);
  assign page_we_ok = PAGE_WE & ~AEN;
  assign inc_ok     = (PAGE_INC != 0) & wrap_det;

  // Page bank muxes; out-of-range channel numbers read as zero.
  always_comb begin
    pg_dma = '0;
    pg_rd  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (DACK_CH == CH_W'(i))  pg_dma = page[i];
      if (PAGE_SEL == CH_W'(i)) pg_rd  = page[i];
    end
  end

  // Transparent-latch emulation: track the bus while the strobe is high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cpu_lo_q <= '0;
      cpu_hi_q <= '0;
      mid_q    <= '0;
    end else begin
      if (ALE) begin
        cpu_lo_q <= AD15_AD0;
        cpu_hi_q <= A_HI;
      end
      if (mid_stb) mid_q <= AD15_AD0[15:8];
    end
  end

  // Middle-byte wrap tracking across successive ADSTB strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      adstb_q    <= 1'b0;
      mid_prev_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      adstb_q <= ADSTB;
      wrap_q  <= wrap_det;
      if (adstb_fall) mid_prev_q <= mid_q;
    end
  end

  // Page registers: CPU writes in CPU mode, optional increment on wrap.
  // Write and increment are mutually exclusive since they need opposite AEN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) page[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (page_we_ok && (PAGE_SEL == CH_W'(i)))
          page[i] <= PAGE_WDATA;
        else if (inc_ok && (DACK_CH == CH_W'(i)))
          page[i] <= page[i] + PG_W'(1);
      end
    end
  end

  assign ADDR_OE_LO = ~AEN;
  assign PAGE_RDATA = pg_rd;
  assign WRAP_PULSE = wrap_q;
  // DMA_A_LO is a live pass-through, so the reset gate keeps Address at zero
  // during reset regardless of bus mode.
  assign Address = !RESET_N ? '0 :
                   AEN      ? {pg_dma, mid_q, DMA_A_LO} :
                              {cpu_hi_q, cpu_lo_q};

endmodule
